// File: rtl/tca9539_pkg.sv
// Shared register map, reset values and controller state encoding for the TCA9539 port block.
package tca9539_pkg;

    localparam logic [7:0] ADDR_INPUT_0    = 8'h00;
    localparam logic [7:0] ADDR_INPUT_1    = 8'h01;
    localparam logic [7:0] ADDR_OUTPUT_0   = 8'h02;
    localparam logic [7:0] ADDR_OUTPUT_1   = 8'h03;
    localparam logic [7:0] ADDR_POLARITY_0 = 8'h04;
    localparam logic [7:0] ADDR_POLARITY_1 = 8'h05;
    localparam logic [7:0] ADDR_CONFIG_0   = 8'h06;
    localparam logic [7:0] ADDR_CONFIG_1   = 8'h07;

    localparam logic [7:0]  RST_BYTE    = 8'h00;
    localparam logic [15:0] RST_PIN_OUT = 16'hFFFF;
    localparam logic [15:0] RST_PIN_OE  = 16'h0000;

    // two synchroniser flops plus the input_port register
    localparam int SYNC_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic int fill_len(input int filter_cycles, input bit filter_en);
        return SYNC_DEPTH + (filter_en ? filter_cycles : 0);
    endfunction

endpackage

// File: rtl/tca9539_port_ctrl_if.sv
// Register-file side of the port controller: configuration bytes in, read strobe, conditioned inputs out.
interface tca9539_port_ctrl_if;
    logic [7:0] output_port_0;
    logic [7:0] output_port_1;
    logic [7:0] polarity_0;
    logic [7:0] polarity_1;
    logic [7:0] config_0;
    logic [7:0] config_1;
    logic       rd_strobe;
    logic [7:0] rd_addr;
    logic [7:0] input_port_0;
    logic [7:0] input_port_1;

    modport master (
        output output_port_0, output_port_1, polarity_0, polarity_1, config_0, config_1,
        output rd_strobe, rd_addr,
        input  input_port_0, input_port_1
    );

    modport slave (
        input  output_port_0, output_port_1, polarity_0, polarity_1, config_0, config_1,
        input  rd_strobe, rd_addr,
        output input_port_0, input_port_1
    );
endinterface

// File: rtl/tca9539_bit_filter.sv
// Per-bit debounce: the accepted level follows the synchronised level only after it has
// differed for FILTER_CYCLES consecutive cycles; any reversion restarts the count.
module tca9539_bit_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_accepted
);

    localparam logic [7:0] CNT_TC = 8'(FILTER_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
            r_acc <= 1'b0;
        end else if (i_sync != r_acc) begin
            if (r_cnt == CNT_TC) begin
                r_acc <= i_sync;
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign o_accepted = r_acc;

endmodule

// File: rtl/tca9539_port_ctrl.sv
// TCA9539 pin-side controller: input conditioning, snapshot-based interrupt, output drive.
// Optional input debounce enabled by defining TCA9539_INPUT_FILTER_EN.
//
// state | meaning
// FILL  | waiting for the input pipeline to hold real pin data
// PRIME | load both snapshots from input_port, interrupt held off
// RUN   | snapshot compare drives int_n, reads reload snapshots
module tca9539_port_ctrl
    import tca9539_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         pin_in,
    tca9539_port_ctrl_if.slave  regs,
    output logic [15:0]         pin_out,
    output logic [15:0]         pin_oe,
    output logic                int_n
);

`ifdef TCA9539_INPUT_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam int         FILL_LEN  = fill_len(FILTER_CYCLES, FILTER_EN);
    localparam logic [8:0] FILL_LOAD = 9'(FILL_LEN - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [8:0]  r_fill_cnt;
    logic        w_fill_done;
    logic        w_prime;
    logic        w_run;

    logic [15:0] r_sync1;
    logic [15:0] r_sync2;
    logic [15:0] w_accepted;
    logic [7:0]  r_input_0;
    logic [7:0]  r_input_1;
    logic [7:0]  r_snap_0;
    logic [7:0]  r_snap_1;
    logic        w_mismatch_0;
    logic        w_mismatch_1;
    logic        r_int_n;
    logic [15:0] r_pin_out;
    logic [15:0] r_pin_oe;

    assign w_fill_done = (r_fill_cnt == 9'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= FILL_LOAD;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FILL && !w_fill_done)
                r_fill_cnt <= r_fill_cnt - 9'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prime     = 1'b0;
        w_run       = 1'b0;
        unique case (r_state)
            ST_FILL:  if (w_fill_done) w_state_nxt = ST_PRIME;
            ST_PRIME: begin
                w_prime     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN:   w_run = 1'b1;
            default:  w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 16'h0000;
            r_sync2 <= 16'h0000;
        end else begin
            r_sync1 <= pin_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef TCA9539_INPUT_FILTER_EN
    for (genvar gi = 0; gi < 16; gi++) begin : g_filt
        tca9539_bit_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
            .clk        (clk),
            .rst        (rst),
            .i_sync     (r_sync2[gi]),
            .o_accepted (w_accepted[gi])
        );
    end
`else
    assign w_accepted = r_sync2;
`endif

    assign w_mismatch_0 = |((r_input_0 ^ r_snap_0) & regs.config_0);
    assign w_mismatch_1 = |((r_input_1 ^ r_snap_1) & regs.config_1);

    // A read captures the input_port value the host just saw, so any later change re-flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_input_0 <= RST_BYTE;
            r_input_1 <= RST_BYTE;
            r_snap_0  <= RST_BYTE;
            r_snap_1  <= RST_BYTE;
            r_int_n   <= 1'b1;
        end else begin
            r_input_0 <= w_accepted[7:0]  ^ regs.polarity_0;
            r_input_1 <= w_accepted[15:8] ^ regs.polarity_1;
            if (w_prime) begin
                r_snap_0 <= r_input_0;
                r_snap_1 <= r_input_1;
            end else if (w_run && regs.rd_strobe) begin
                if (regs.rd_addr == ADDR_INPUT_0) r_snap_0 <= r_input_0;
                if (regs.rd_addr == ADDR_INPUT_1) r_snap_1 <= r_input_1;
            end
            r_int_n <= w_run ? ~(w_mismatch_0 | w_mismatch_1) : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pin_out <= RST_PIN_OUT;
            r_pin_oe  <= RST_PIN_OE;
        end else begin
            r_pin_out <= {regs.output_port_1, regs.output_port_0};
            r_pin_oe  <= ~{regs.config_1, regs.config_0};
        end
    end

    assign regs.input_port_0 = r_input_0;
    assign regs.input_port_1 = r_input_1;
    assign pin_out           = r_pin_out;
    assign pin_oe            = r_pin_oe;
    assign int_n             = r_int_n;

endmodule

// File: tb/tb_tca9539_port_ctrl.sv
// Directed bench for tca9539_port_ctrl: table-driven conditioning vectors plus
// hand-timed interrupt/snapshot sequences; debounce cases only when the filter is built in.
module tb_tca9539_port_ctrl;

`ifdef TCA9539_INPUT_FILTER_EN
    localparam int LAT = 3 + 4;
    localparam int PW  = 4;
`else
    localparam int LAT = 3;
    localparam int PW  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pin_in;
    logic [15:0] pin_out;
    logic [15:0] pin_oe;
    logic        int_n;

    int n_pass  = 0;
    int n_total = 0;

    tca9539_port_ctrl_if u_if ();

    tca9539_port_ctrl #(.FILTER_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .pin_in  (pin_in),
        .regs    (u_if),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .int_n   (int_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pin;
        logic [7:0]  op0, op1, pol0, pol1, cfg0, cfg1;
        logic [7:0]  exp_in0, exp_in1;
        logic [15:0] exp_pout, exp_poe;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] addr);
        u_if.rd_addr   = addr;
        u_if.rd_strobe = 1'b1;
        step(1);
        u_if.rd_strobe = 1'b0;
        u_if.rd_addr   = 8'hFF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h1234, 8'h55, 8'hAA, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h34, 8'h12, 16'hAA55, 16'h0000};
        vecs[1] = '{16'h1234, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h0F, 8'hF0, 8'hCB, 8'h12, 16'hFF00, 16'h0FF0};
        vecs[2] = '{16'hABCD, 8'h81, 8'h18, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'hC2, 8'h5B, 16'h1881, 16'hFFFF};
        vecs[3] = '{16'hFFFF, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h3C, 8'hC3, 8'h55, 8'hAA, 16'h0000, 16'h3CC3};
        vecs[4] = '{16'h0000, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 16'hFFFF, 16'h0000};

        rst                = 1'b1;
        pin_in             = 16'h00FF;
        u_if.output_port_0 = 8'hA5;
        u_if.output_port_1 = 8'h3C;
        u_if.polarity_0    = 8'h00;
        u_if.polarity_1    = 8'h00;
        u_if.config_0      = 8'hFF;
        u_if.config_1      = 8'hFF;
        u_if.rd_strobe     = 1'b0;
        u_if.rd_addr       = 8'hFF;
        step(3);

        chk("rst_pin_out", pin_out, 16'hFFFF);
        chk("rst_pin_oe", pin_oe, 16'h0000);
        chk("rst_int_n", int_n, 1'b1);
        chk("rst_in0", u_if.input_port_0, 8'h00);

        // start-up fill / prime
        rst = 1'b0;
        step(1);
        chk("pin_out_follow", pin_out, 16'h3CA5);
        step(LAT - 2);
        chk("fill_in0_pre", u_if.input_port_0, 8'h00);
        step(1);
        chk("fill_in0", u_if.input_port_0, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("fill_prime_int_n", int_n, 1'b1);
        end

        // port 0 bit 3 falls, ignored addresses, then a real read
        pin_in = 16'h00F7;
        step(LAT - 1);
        chk("p0_pre_latency", u_if.input_port_0, 8'hFF);
        step(1);
        chk("p0_latency", u_if.input_port_0, 8'hF7);
        chk("p0_int_not_yet", int_n, 1'b1);
        step(1);
        chk("p0_int_assert", int_n, 1'b0);
        rd(8'h02);
        rd(8'h07);
        rd(8'h01);
        rd(8'h80);
        step(1);
        chk("ignored_addr_int", int_n, 1'b0);
        rd(8'h00);
        step(1);
        chk("rd0_clears_int", int_n, 1'b1);

        // port 1 configured as outputs: inputs still visible, no interrupt
        u_if.config_1 = 8'h00;
        step(1);
        chk("oe_port1", pin_oe, 16'hFF00);
        pin_in = 16'hA5F7;
        step(LAT);
        chk("p1_out_in_a", u_if.input_port_1, 8'hA5);
        step(2);
        chk("p1_out_int_a", int_n, 1'b1);
        pin_in = 16'h5AF7;
        step(LAT);
        chk("p1_out_in_b", u_if.input_port_1, 8'h5A);
        step(2);
        chk("p1_out_int_b", int_n, 1'b1);
        pin_in = 16'h00F7;
        step(LAT + 1);
        u_if.config_1 = 8'hFF;
        step(2);
        chk("cfg1_restore_int", int_n, 1'b1);

        // polarity inversion and a short pulse that returns without a read
        pin_in          = 16'h00FF;
        u_if.polarity_0 = 8'h0F;
        step(LAT + 1);
        chk("pol_in0", u_if.input_port_0, 8'hF0);
        rd(8'h00);
        step(1);
        chk("pol_resync_int", int_n, 1'b1);
        pin_in = 16'h00FE;
        step(PW);
        pin_in = 16'h00FF;
        step(LAT - PW);
        chk("pulse_in0", u_if.input_port_0, 8'hF1);
        step(1);
        chk("pulse_int_low", int_n, 1'b0);
        step(PW);
        chk("pulse_int_high", int_n, 1'b1);
        chk("pulse_in0_back", u_if.input_port_0, 8'hF0);

        // port-0 read in the same cycle port 1 changes
        pin_in = 16'h007F;
        step(LAT + 1);
        chk("p0_bit7_int", int_n, 1'b0);
        pin_in = 16'h017F;
        step(LAT);
        rd(8'h00);
        step(1);
        chk("rd0_with_p1_change", int_n, 1'b0);
        rd(8'h01);
        step(1);
        chk("rd1_clears_int", int_n, 1'b1);

        // change landing on the edge of a read is not masked
        pin_in = 16'h037F;
        step(LAT - 1);
        rd(8'h01);
        step(1);
        chk("post_read_change", int_n, 1'b0);
        rd(8'h01);
        step(1);
        chk("post_read_clear", int_n, 1'b1);

        for (int v = 0; v < 5; v++) begin
            pin_in             = vecs[v].pin;
            u_if.output_port_0 = vecs[v].op0;
            u_if.output_port_1 = vecs[v].op1;
            u_if.polarity_0    = vecs[v].pol0;
            u_if.polarity_1    = vecs[v].pol1;
            u_if.config_0      = vecs[v].cfg0;
            u_if.config_1      = vecs[v].cfg1;
            step(LAT + 1);
            chk($sformatf("vec%0d_in0", v), u_if.input_port_0, vecs[v].exp_in0);
            chk($sformatf("vec%0d_in1", v), u_if.input_port_1, vecs[v].exp_in1);
            chk($sformatf("vec%0d_pin_out", v), pin_out, vecs[v].exp_pout);
            chk($sformatf("vec%0d_pin_oe", v), pin_oe, vecs[v].exp_poe);
            rd(8'h00);
            rd(8'h01);
        end
        step(2);
        chk("table_exit_int", int_n, 1'b1);

        // reset while an interrupt is pending
        pin_in = 16'h0001;
        step(LAT + 2);
        chk("pre_rst_int", int_n, 1'b0);
        rst = 1'b1;
        step(1);
        chk("midrst_int_n", int_n, 1'b1);
        chk("midrst_in0", u_if.input_port_0, 8'h00);
        chk("midrst_pin_out", pin_out, 16'hFFFF);
        chk("midrst_pin_oe", pin_oe, 16'h0000);
        step(1);
        rst = 1'b0;
        step(LAT - 1);
        chk("refill_in0_pre", u_if.input_port_0, 8'h00);
        step(1);
        chk("refill_in0", u_if.input_port_0, 8'h01);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("refill_int_n", int_n, 1'b1);
        end

`ifdef TCA9539_INPUT_FILTER_EN
        pin_in = 16'h0005;
        step(LAT + 2);
        chk("filt_base", u_if.input_port_0, 8'h05);
        pin_in = 16'h0001;
        step(3);
        pin_in = 16'h0005;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("filt_glitch_rejected", u_if.input_port_0, 8'h05);
        end
        pin_in = 16'h0001;
        step(6);
        chk("filt_low_pre", u_if.input_port_0, 8'h05);
        pin_in = 16'h0005;
        step(1);
        chk("filt_low_accepted", u_if.input_port_0, 8'h01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tca9539_port_ctrl.md
TCA9539_PORT_CTRL -- requirements
Module: tca9539_port_ctrl

Interface
REQ-001 SHALL have parameter: FILTER_CYCLES, default 4, consecutive stable cycles before a filtered input bit is accepted (range 1..255).
REQ-002 SHALL have port: clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: pin_in  in  16  raw asynchronous pin levels; [7:0] = port 0, [15:8] = port 1.
REQ-005 SHALL have ports: output_port_0, output_port_1, polarity_0, polarity_1, config_0, config_1  in  8 each  register-file values; config bit 1 = input.
REQ-006 SHALL have port: rd_strobe  in  1  one-cycle pulse, I2C read of register rd_addr completed.
REQ-007 SHALL have port: rd_addr  in  8  register address qualified by rd_strobe.
REQ-008 SHALL have ports: input_port_0, input_port_1  out  8 each  conditioned input values to the register file.
REQ-009 SHALL have port: pin_out  out  16  {output_port_1, output_port_0}, registered.
REQ-010 SHALL have port: pin_oe  out  16  ~{config_1, config_0}, registered.
REQ-011 SHALL have port: int_n  out  1  active-low interrupt, registered.

Function
REQ-012 SHALL synchronise pin_in through two flops per bit.
REQ-013 SHALL form input_port_N = accepted_N XOR polarity_N, registered; unfiltered latency pin_in to input_port = 3 cycles.
REQ-014 SHALL hold snapshot registers snap_0, snap_1; mismatch_N = |((input_port_N ^ snap_N) & config_N).
REQ-015 SHALL drive int_n = ~(mismatch_0 | mismatch_1), one cycle after the mismatch; a bit returning to its snapshot value with no read deasserts int_n.
REQ-016 SHALL, on rd_strobe with rd_addr 8'h00 (8'h01), load snap_0 (snap_1) with input_port_0 (input_port_1) from that same cycle; the other snapshot is unaffected.
REQ-017 SHALL, when input_port changes in the cycle after a read, re-assert int_n one cycle later; a read never masks a later change.
REQ-018 SHALL ignore changes on bits with config = 0 for interrupt purposes; they still appear on input_port.
REQ-019 SHALL ignore rd_strobe for any rd_addr other than 8'h00/8'h01.
REQ-020 SHALL implement FSM FILL -> PRIME -> RUN: FILL counts pipeline depth (3, plus FILTER_CYCLES when filtered); PRIME loads both snapshots for one cycle; RUN is steady state.
REQ-021 SHALL hold int_n = 1 and ignore rd_strobe in FILL and PRIME.
REQ-022 SHALL update pin_out and pin_oe one cycle after their register inputs change, in all FSM states.

Reset
REQ-023 SHALL on rst: FSM to FILL; sync flops, accepted, input_port_0/1, snap_0/1 to 8'h00; int_n 1; pin_out 16'hFFFF; pin_oe 16'h0000; filter counters 0.
REQ-024 SHALL, on rst asserted mid-operation, restart FILL regardless of pending reads or interrupts.

Configuration
REQ-025 SHALL, with TCA9539_INPUT_FILTER_EN defined, make accepted bit change only after the synchronised bit differs from accepted for FILTER_CYCLES consecutive cycles; any reversion clears that bit's counter.
REQ-026 SHALL, without TCA9539_INPUT_FILTER_EN, set accepted = synchronised value; FILTER_CYCLES unused; FILL length 3.

Structure
REQ-027 SHALL take register addresses 8'h00-8'h07, reset values and FSM state encoding from shared package tca9539_pkg.
REQ-028 SHALL place the per-bit filter in sub-module tca9539_bit_filter, instanced 16 times only under TCA9539_INPUT_FILTER_EN.

Verification
REQ-029 SHALL cover: rst, pin_in=16'h00FF, config=FF/FF, polarity=0 -> after FILL/PRIME input_port_0=8'hFF, int_n stays 1.
REQ-030 SHALL cover: pin_in[3] 1->0 in RUN -> input_port_0=8'hF7 after 3 cycles, int_n=0 one cycle later; rd_strobe addr 8'h00 -> int_n=1 one cycle after.
REQ-031 SHALL cover: config_1=8'h00, pin_in[15:8] toggles -> input_port_1 follows, int_n stays 1; pin_oe[15:8]=8'hFF.
REQ-032 SHALL cover: polarity_0=8'h0F with pin_in[7:0]=8'hFF -> input_port_0=8'hF0; pin_in[0] pulse 0 then back to 1 -> int_n low then high, no read.
REQ-033 SHALL cover: port-0 read coincident with port-1 change -> snap_0 loaded, int_n=0 from port 1 mismatch.
REQ-034 SHALL cover (filter enabled, FILTER_CYCLES=4): 3-cycle glitch on pin_in[2] -> no input_port change; 6-cycle low -> input_port_0[2]=0 at 3+4 cycles.
